// File: rtl/chip_dat_rx.sv
// chip_dat_rx: CHIP_DAT pad receiver; packs data beats into FIFO-buffered words and holds commands in a one-entry register.
module chip_dat_rx #(
    parameter int CHIP_DAT_DW = 8,
    parameter int PACK = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int WORD_DW = PACK * CHIP_DAT_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   chip_dat_vld,
    input  logic                   chip_dat_lst,
    input  logic                   chip_dat_cmd,
    input  logic [CHIP_DAT_DW-1:0] chip_dat_dat,
    output logic                   chip_dat_rdy,
    output logic                   cmd_vld,
    output logic [CHIP_DAT_DW-1:0] cmd_dat,
    input  logic                   cmd_rdy,
    output logic                   wrd_vld,
    output logic [WORD_DW-1:0]     wrd_dat,
    output logic                   wrd_lst,
    input  logic                   wrd_rdy,
    output logic                   err
);
    localparam int BW = $clog2(PACK);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PACK - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic                   armed_q, armed_d;
    logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [WORD_DW-1:0]     asm_q, asm_d, lane_dat;
    logic                   cmd_vld_q, cmd_vld_d;
    logic [CHIP_DAT_DW-1:0] cmd_dat_q, cmd_dat_d;
    logic                   err_q, err_d;
    logic [FIFO_DEPTH-1:0][WORD_DW-1:0] mem_q, mem_d;
    logic [FIFO_DEPTH-1:0]  lst_q, lst_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   fifo_full_q, fifo_full_d;
    logic                   acc, push, pop;

    assign chip_dat_rdy = armed_q && !fifo_full_q && !cmd_vld_q;
    assign acc          = chip_dat_vld && chip_dat_rdy;
    assign wrd_vld      = cnt_q != '0;
    assign pop          = wrd_vld && wrd_rdy;
    assign wrd_dat      = mem_q[rd_ptr_q];
    assign wrd_lst      = lst_q[rd_ptr_q];
    assign cmd_vld      = cmd_vld_q;
    assign cmd_dat      = cmd_dat_q;
    assign err          = err_q;

    always_comb begin
        armed_d    = 1'b1;
        beat_cnt_d = beat_cnt_q;
        asm_d      = asm_q;
        cmd_vld_d  = cmd_vld_q && !cmd_rdy;
        cmd_dat_d  = cmd_dat_q;
        err_d      = err_q;
        push       = 1'b0;
        lane_dat   = asm_q;
        for (int i = 0; i < PACK; i++)
            if (beat_cnt_q == BW'(i)) lane_dat[i*CHIP_DAT_DW +: CHIP_DAT_DW] = chip_dat_dat;
        if (acc && !chip_dat_cmd) begin
            push       = (beat_cnt_q == LAST_BEAT) || chip_dat_lst;
            beat_cnt_d = push ? '0 : beat_cnt_q + 1'b1;
            asm_d      = push ? '0 : lane_dat;
        end
        if (acc && chip_dat_cmd) begin
            cmd_vld_d  = 1'b1;
            cmd_dat_d  = chip_dat_dat;
            err_d      = err_q || (beat_cnt_q != '0);
            beat_cnt_d = '0;
            asm_d      = '0;
        end
        mem_d = mem_q;
        lst_d = lst_q;
        if (push) begin
            mem_d[wr_ptr_q] = lane_dat;
            lst_d[wr_ptr_q] = chip_dat_lst;
        end
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d       = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
        fifo_full_d = cnt_d == FULL_CNT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            cmd_vld_q   <= 1'b0;
            cmd_dat_q   <= '0;
            err_q       <= 1'b0;
            mem_q       <= '0;
            lst_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            fifo_full_q <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_dat_q   <= cmd_dat_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
            lst_q       <= lst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            fifo_full_q <= fifo_full_d;
        end
    end
endmodule

// File: tb/tb_chip_dat_rx.sv
// tb_chip_dat_rx: scoreboard bench; a packet-level model predicts words, commands, err and rdy from accepted beats.
module tb_chip_dat_rx;
    localparam int PACK = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        chip_dat_vld = 1'b0, chip_dat_lst = 1'b0, chip_dat_cmd = 1'b0;
    logic [7:0]  chip_dat_dat = '0;
    logic        chip_dat_rdy, cmd_vld, wrd_vld, wrd_lst, err;
    logic [7:0]  cmd_dat;
    logic [31:0] wrd_dat;
    logic        cmd_rdy = 1'b0, wrd_rdy = 1'b0;

    int          checks = 0, errors = 0, acc_cnt = 0, edges = 0;
    logic [32:0] wq[$];
    logic [7:0]  cq[$];
    logic [7:0]  part[$];
    logic        exp_err = 1'b0;
    logic [32:0] last_pop = '0;
    bit          rand_mode = 0;

    chip_dat_rx dut (
        .clk(clk), .rst_n(rst_n),
        .chip_dat_vld(chip_dat_vld), .chip_dat_lst(chip_dat_lst),
        .chip_dat_cmd(chip_dat_cmd), .chip_dat_dat(chip_dat_dat),
        .chip_dat_rdy(chip_dat_rdy),
        .cmd_vld(cmd_vld), .cmd_dat(cmd_dat), .cmd_rdy(cmd_rdy),
        .wrd_vld(wrd_vld), .wrd_dat(wrd_dat), .wrd_lst(wrd_lst), .wrd_rdy(wrd_rdy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else if (edges < 2) edges <= edges + 1;

    // Model: compare current outputs against prior handshakes, then fold in this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete(); cq.delete(); part.delete(); exp_err = 1'b0;
        end else begin
            chk("rdy", chip_dat_rdy, edges >= 1 && wq.size() < DEPTH && cq.size() == 0);
            chk("wrd_vld", wrd_vld, wq.size() != 0);
            chk("cmd_vld", cmd_vld, cq.size() != 0);
            chk("err", err, exp_err);
            if (wrd_vld && wrd_rdy && wq.size() != 0) begin
                chk("word", {wrd_lst, wrd_dat}, wq.pop_front());
                last_pop = {wrd_lst, wrd_dat};
            end
            if (cmd_vld && cmd_rdy && cq.size() != 0) chk("cmd", cmd_dat, cq.pop_front());
            if (chip_dat_vld && chip_dat_rdy) begin
                acc_cnt++;
                if (chip_dat_cmd) begin
                    if (part.size() != 0) exp_err = 1'b1;
                    part.delete();
                    cq.push_back(chip_dat_dat);
                end else begin
                    part.push_back(chip_dat_dat);
                    if (part.size() == PACK || chip_dat_lst) begin
                        logic [31:0] w;
                        w = '0;
                        foreach (part[i]) w[i*8 +: 8] = part[i];
                        wq.push_back({chip_dat_lst, w});
                        part.delete();
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            wrd_rdy = 1'($urandom_range(0, 1));
            cmd_rdy = $urandom_range(0, 3) == 0;
        end
    end

    task automatic send(input logic c, input logic l, input logic [7:0] d);
        bit ok;
        int g;
        chip_dat_cmd = c; chip_dat_lst = l; chip_dat_dat = d; chip_dat_vld = 1'b1;
        g = 0;
        do begin
            @(negedge clk); ok = chip_dat_rdy;
            @(posedge clk); #1; g++;
        end while (!ok && g < 200);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %0h not accepted, required acceptance within 200 cycles", d);
        end
        chip_dat_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_rdy"}, chip_dat_rdy, 0);
        chk({n, "_wrd_vld"}, wrd_vld, 0);
        chk({n, "_wrd_dat"}, wrd_dat, 0);
        chk({n, "_wrd_lst"}, wrd_lst, 0);
        chk({n, "_cmd_vld"}, cmd_vld, 0);
        chk({n, "_cmd_dat"}, cmd_dat, 0);
        chk({n, "_err"}, err, 0);
    endtask

    initial begin
        int a0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        wrd_rdy = 1'b1; cmd_rdy = 1'b1;
        @(negedge clk); chk("rdy_release_cycle", chip_dat_rdy, 0);
        @(negedge clk); chk("rdy_second_edge", chip_dat_rdy, 1);
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) send(1'b0, i == 8, 8'(i));
        for (int i = 0; i < 3; i++) send(1'b0, i == 2, 8'hAA + 8'(i * 17));
        repeat (2) @(negedge clk);
        chk("streamB_word", last_pop, {1'b1, 32'h00CCBBAA});
        @(posedge clk); #1 cmd_rdy = 1'b0;
        send(1'b1, 1'b1, 8'h5A);
        repeat (5) begin
            @(negedge clk);
            chk("streamC_cmd_dat", cmd_dat, 8'h5A);
            chk("streamC_rdy_low", chip_dat_rdy, 0);
        end
        @(posedge clk); #1 cmd_rdy = 1'b1;
        @(posedge clk); #1 cmd_rdy = 1'b0;
        @(negedge clk); chk("streamC_rdy_back", chip_dat_rdy, 1);
        @(posedge clk); #1 wrd_rdy = 1'b0;
        a0 = acc_cnt;
        fork
            for (int i = 0; i < 20; i++) send(1'b0, 1'b0, 8'(8'h20 + i));
            begin
                repeat (40) @(negedge clk);
                chk("streamD_accepted", acc_cnt - a0, 16);
                chk("streamD_rdy_full", chip_dat_rdy, 0);
                @(posedge clk); #1 wrd_rdy = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        send(1'b0, 1'b0, 8'h11);
        send(1'b0, 1'b0, 8'h22);
        send(1'b1, 1'b0, 8'h33);
        @(negedge clk);
        chk("streamE_cmd_dat", cmd_dat, 8'h33);
        chk("streamE_err", err, 1);
        chk("streamE_no_word", wrd_vld, 0);
        @(posedge clk); #1 cmd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 8'(8'h44 + i));
        repeat (2) @(negedge clk);
        chk("streamE_word", last_pop, {1'b0, 32'h47464544});
        @(posedge clk); #1 wrd_rdy = 1'b0;
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 8'(8'h80 + i));
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_reset_outputs("streamF");
        @(posedge clk); #1 rst_n = 1'b1; wrd_rdy = 1'b1;
        @(negedge clk); chk("streamF_rdy_first", chip_dat_rdy, 0);
        @(negedge clk); chk("streamF_rdy_second", chip_dat_rdy, 1);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send(1'b0, 1'b0, 8'(8'h90 + i));
        repeat (2) @(negedge clk);
        chk("streamF_word", last_pop, {1'b0, 32'h94939291});
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 send($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
        end
        rand_mode = 0;
        @(posedge clk); #2 wrd_rdy = 1'b1; cmd_rdy = 1'b1;
        repeat (20) @(negedge clk);
        chk("drain_words", wq.size(), 0);
        chk("drain_cmds", cq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
